vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock.
- Outputs: a pixel-rate enable, a divided pixel clock, horizontal/vertical sync, raster coordinates and a display-area flag.
- Sits directly upstream of the pattern/pixel generator in `top`, which consumes `pixel_x`, `pixel_y` and `in_display_area` to choose colour.
- Single clock domain; all outputs are registered.

## Interface

Parameters (default, meaning):
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active sync level (0 = active-low)

Derived values:
- H_TOTAL = sum of the H_* parameters (800).
- V_TOTAL = sum of the V_* parameters (525).
- Both totals must be ≤ 1024.

Ports (direction, width, meaning):
- `clk_50`, in, 1, 50 MHz system clock
- `rst_n`, in, 1, asynchronous active-low reset
- `pix_en`, out, 1, pixel-rate strobe, high every second `clk_50` cycle
- `vga_clk`, out, 1, registered divide-by-2 of `clk_50`, high during `pix_en` cycles
- `pixel_x`, out, 10, horizontal counter, 0..H_TOTAL-1
- `pixel_y`, out, 10, vertical counter, 0..V_TOTAL-1
- `in_display_area`, out, 1, high when x < H_ACTIVE and y < V_ACTIVE
- `vga_hs`, out, 1, horizontal sync
- `vga_vs`, out, 1, vertical sync
- `line_start`, out, 1, high while pixel_x == 0
- `frame_start`, out, 1, high while pixel_x == 0 and pixel_y == 0

## Operation

**Divider**
- A 1-bit divider toggles on every `clk_50` edge.
- `pix_en` is the registered divider phase.
- `vga_clk` equals `pix_en`.

**Counters**
- The counters advance only on `clk_50` edges where `pix_en` is sampled high.
- On each advance, x increments. At H_TOTAL-1, x wraps to 0 and y increments.
- When y is at V_TOTAL-1 and x wraps, y also wraps to 0.
- The counters are plain 10-bit registers. `pixel_x` and `pixel_y` are the counter values themselves, not clamped to the active area.

**Decodes**
- Every decode is registered and computed from the next-state counter value, so it always describes the current `pixel_x`/`pixel_y`.
- hsync is active for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is active for V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491).
- vsync transitions coincide with x wrapping to 0.
- Sync polarity: output = SYNC_POL when active, ~SYNC_POL when inactive.

**Reset**
- The counters reset to the last raster position, x = H_TOTAL-1 and y = V_TOTAL-1.
- The first advance therefore lands on (0,0) with `frame_start` set.

**Reset values**
- pix_en = 0, vga_clk = 0
- pixel_x = 799, pixel_y = 524
- in_display_area = 0, line_start = 0, frame_start = 0
- vga_hs = vga_vs = ~SYNC_POL (inactive)

**Reset mid-operation**
- Asserting `rst_n` low forces all outputs to their reset values immediately (asynchronous), whatever the raster position.
- Release restarts the sequence exactly as after power-up.

## Timing

**Start-up**
- 1st rising `clk_50` edge after `rst_n` deasserts: pix_en becomes 1.
- 2nd edge: counters advance to (0,0). in_display_area, line_start and frame_start become 1. pix_en becomes 0.

**Steady state**
- Each pixel lasts 2 `clk_50` cycles.
- Each line lasts 1600 cycles.
- Each frame lasts 840,000 cycles (59.52 Hz).

**Sync pulses**
- hsync: active 192 cycles, asserted on the edge where x becomes 656 and released when x becomes 752.
- vsync: active 2 lines (3200 cycles), asserted when (x,y) becomes (0,490) and released at (0,492).

**Active-area boundaries**
- in_display_area falls when x becomes 640, and rises again when x becomes 0 on lines y < 480.
- It stays low for all of lines 480..524.

**Latency**
- No output lags its counter. All outputs change on the same edge.

## Test plan

1. **Reset values.** Hold `rst_n` low 10 cycles -> pixel_x = 799, pixel_y = 524, vga_hs = vga_vs = 1, in_display_area = 0, pix_en = 0.
2. **Start-up.** Release reset -> exactly 2 edges later (0,0) with frame_start = 1 and in_display_area = 1. pix_en alternates 1,0 from edge 1.
3. **Horizontal timing.** Run 3 lines ->
   - line period 1600 cycles;
   - vga_hs low exactly 192 cycles, starting at x = 656;
   - in_display_area low from x = 640 to 799;
   - line_start high 2 cycles per line.
4. **Vertical timing.** Run 2 frames ->
   - frame period 840,000 cycles;
   - vga_vs low exactly 3200 cycles, starting at (0,490);
   - pixel_y wraps 524 -> 0 together with pixel_x wrapping 799 -> 0.
5. **Mid-frame reset.** Assert `rst_n` low at (320,240) -> outputs reach reset values with no clock edge. Release -> repeat scenario 2 exactly.
6. **Sync polarity.** Set SYNC_POL = 1 -> both syncs idle at 0 and are high only during their windows. Window positions are unchanged.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing from clk_50 with a registered divide-by-2 pixel strobe.
// Decodes come from the next counter values, so every output matches the current pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_50,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       in_display_area,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic       x_wrap;
  logic [9:0] x_nxt, y_nxt;
  always_comb begin
    x_wrap = pix_en && pixel_x == X_LAST;
    x_nxt  = x_wrap ? '0 : pixel_x + 10'(pix_en);
    y_nxt  = x_wrap ? (pixel_y == Y_LAST ? '0 : pixel_y + 10'd1) : pixel_y;
  end
  // Reset parks the raster on its last position so the first advance lands on (0,0).
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      pix_en          <= 1'b0;
      vga_clk         <= 1'b0;
      pixel_x         <= X_LAST;
      pixel_y         <= Y_LAST;
      in_display_area <= 1'b0;
      vga_hs          <= ~SYNC_POL;
      vga_vs          <= ~SYNC_POL;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      pix_en          <= ~pix_en;
      vga_clk         <= ~pix_en;
      pixel_x         <= x_nxt;
      pixel_y         <= y_nxt;
      in_display_area <= x_nxt < X_ACT && y_nxt < Y_ACT;
      vga_hs          <= (x_nxt >= HS_ON && x_nxt < HS_OFF) ? SYNC_POL : ~SYNC_POL;
      vga_vs          <= (y_nxt >= VS_ON && y_nxt < VS_OFF) ? SYNC_POL : ~SYNC_POL;
      line_start      <= x_nxt == '0;
      frame_start     <= x_nxt == '0 && y_nxt == '0;
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of the default 640x480 timing, plus a tiny
// active-high-sync raster (16x11) that makes whole frames and a mid-frame reset affordable.
module tb_vga_sync_gen;
  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic       pe_a, vc_a, ide_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, vc_b, ide_b, hs_b, vs_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  int errs = 0, n_chk = 0;
  int hs_lo, ide_lo, ls_hi, pe_bad, ls_r0, ls_r1, hs_on_x, hs_off_x, ide_off_x;
  int vs_hi, hs_hi, fs_r0, fs_r1, vs_on_x, vs_on_y, wraps, wrap_bad, mism, mx, my;
  logic ls_p, hs_p, ide_p, vs_p, fs_p, mpe;
  logic [9:0] y_p, x_p;
  logic found;

  vga_sync_gen dut_a (
    .clk_50(clk), .rst_n(rst_a_n), .pix_en(pe_a), .vga_clk(vc_a),
    .pixel_x(x_a), .pixel_y(y_a), .in_display_area(ide_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk_50(clk), .rst_n(rst_b_n), .pix_en(pe_b), .vga_clk(vc_b),
    .pixel_x(x_b), .pixel_y(y_b), .in_display_area(ide_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic startup_a(input string p);
    @(negedge clk);
    chk({p, "_pe_edge1"}, pe_a, 1);
    chk({p, "_x_edge1"}, x_a, 799);
    @(negedge clk);
    chk({p, "_x_edge2"}, x_a, 0);
    chk({p, "_y_edge2"}, y_a, 0);
    chk({p, "_fs_edge2"}, fs_a, 1);
    chk({p, "_ide_edge2"}, ide_a, 1);
    chk({p, "_ls_edge2"}, ls_a, 1);
    chk({p, "_pe_edge2"}, pe_a, 0);
    chk({p, "_vclk_edge2"}, vc_a, 0);
  endtask

  // Reference raster for dut_b: one pixel per two edges, 16x11, syncs active-high.
  task automatic step_b();
    logic [26:0] exp;
    @(negedge clk);
    if (mpe) begin
      if (mx == 15) begin
        mx = 0;
        my = (my == 10) ? 0 : my + 1;
      end else mx++;
    end
    mpe = ~mpe;
    exp = {mpe, mpe, 10'(mx), 10'(my), mx < 8 && my < 6, mx >= 10 && mx < 13,
           my >= 7 && my < 9, mx == 0, mx == 0 && my == 0};
    if ({pe_b, vc_b, x_b, y_b, ide_b, hs_b, vs_b, ls_b, fs_b} !== exp) mism++;
  endtask

  task automatic reset_vals_b(input string p);
    chk({p, "_x"}, x_b, 15);
    chk({p, "_y"}, y_b, 10);
    chk({p, "_hs"}, hs_b, 0);
    chk({p, "_vs"}, vs_b, 0);
    chk({p, "_pe"}, pe_b, 0);
    chk({p, "_vclk"}, vc_b, 0);
    chk({p, "_ide"}, ide_b, 0);
    chk({p, "_fs"}, fs_b, 0);
  endtask

  initial begin
    repeat (10) @(negedge clk);
    chk("a_rst_x", x_a, 799);
    chk("a_rst_y", y_a, 524);
    chk("a_rst_hs", hs_a, 1);
    chk("a_rst_vs", vs_a, 1);
    chk("a_rst_ide", ide_a, 0);
    chk("a_rst_pe", pe_a, 0);
    chk("a_rst_vclk", vc_a, 0);
    chk("a_rst_ls", ls_a, 0);
    chk("a_rst_fs", fs_a, 0);
    rst_a_n = 1'b1;
    startup_a("a_start");
    hs_lo = 0; ide_lo = 0; ls_hi = 0; pe_bad = 0; ls_r0 = -1; ls_r1 = -1;
    hs_on_x = -1; hs_off_x = -1; ide_off_x = -1;
    ls_p = 1'b0; hs_p = 1'b1; ide_p = 1'b1;
    for (int k = 0; k < 4800; k++) begin
      if (!hs_a) hs_lo++;
      if (!ide_a) ide_lo++;
      if (ls_a) ls_hi++;
      if (hs_p && !hs_a && hs_on_x < 0) hs_on_x = int'(x_a);
      if (!hs_p && hs_a && hs_off_x < 0) hs_off_x = int'(x_a);
      if (ide_p && !ide_a && ide_off_x < 0) ide_off_x = int'(x_a);
      if (ls_a && !ls_p) begin
        if (ls_r0 < 0) ls_r0 = k;
        else if (ls_r1 < 0) ls_r1 = k;
      end
      if (pe_a !== (k % 2 == 1)) pe_bad++;
      ls_p = ls_a; hs_p = hs_a; ide_p = ide_a;
      @(negedge clk);
    end
    chk("a_line_period", ls_r1 - ls_r0, 1600);
    chk("a_hs_low_cycles", hs_lo, 576);
    chk("a_hs_on_x", hs_on_x, 656);
    chk("a_hs_off_x", hs_off_x, 752);
    chk("a_ide_low_cycles", ide_lo, 960);
    chk("a_ide_off_x", ide_off_x, 640);
    chk("a_ls_high_cycles", ls_hi, 6);
    chk("a_pe_alternate_bad", pe_bad, 0);
    chk("a_vs_idle", vs_a, 1);
    chk("a_after3_x", x_a, 0);
    chk("a_after3_y", y_a, 3);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (x_a == 10'd320) found = 1'b1;
      else @(negedge clk);
    end
    chk("a_reach_x320", found, 1);
    #3 rst_a_n = 1'b0;
    #1;
    chk("a_midrst_x", x_a, 799);
    chk("a_midrst_y", y_a, 524);
    chk("a_midrst_ide", ide_a, 0);
    chk("a_midrst_hs", hs_a, 1);
    chk("a_midrst_pe", pe_a, 0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    startup_a("a_restart");

    reset_vals_b("b_rst");
    chk("b_rst_ls", ls_b, 0);
    rst_b_n = 1'b1;
    mpe = 1'b0; mx = 15; my = 10; mism = 0;
    vs_hi = 0; hs_hi = 0; fs_r0 = -1; fs_r1 = -1; vs_on_x = -1; vs_on_y = -1;
    wraps = 0; wrap_bad = 0; vs_p = 1'b0; fs_p = 1'b0; y_p = 10'd10; x_p = 10'd15;
    for (int k = 0; k < 706; k++) begin
      step_b();
      if (vs_b) vs_hi++;
      if (hs_b) hs_hi++;
      if (vs_b && !vs_p && vs_on_x < 0) begin
        vs_on_x = int'(x_b);
        vs_on_y = int'(y_b);
      end
      if (fs_b && !fs_p) begin
        if (fs_r0 < 0) fs_r0 = k;
        else if (fs_r1 < 0) fs_r1 = k;
      end
      if (y_p == 10'd10 && y_b == 10'd0) begin
        wraps++;
        if (!(x_p == 10'd15 && x_b == 10'd0)) wrap_bad++;
      end
      vs_p = vs_b; fs_p = fs_b; y_p = y_b; x_p = x_b;
    end
    chk("b_model_mismatches", mism, 0);
    chk("b_frame_period", fs_r1 - fs_r0, 352);
    chk("b_vs_high_cycles", vs_hi, 128);
    chk("b_hs_high_cycles", hs_hi, 132);
    chk("b_vs_on_x", vs_on_x, 0);
    chk("b_vs_on_y", vs_on_y, 7);
    chk("b_y_wraps", wraps, 3);
    chk("b_wrap_with_x_bad", wrap_bad, 0);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (x_b == 10'd4 && y_b == 10'd3) found = 1'b1;
      else @(negedge clk);
    end
    chk("b_reach_4_3", found, 1);
    chk("b_pre_rst_ide", ide_b, 1);
    #3 rst_b_n = 1'b0;
    #1;
    reset_vals_b("b_midrst");
    repeat (3) @(negedge clk);
    rst_b_n = 1'b1;
    mpe = 1'b0; mx = 15; my = 10; mism = 0;
    step_b();
    chk("b_restart_pe_edge1", pe_b, 1);
    step_b();
    chk("b_restart_fs_edge2", fs_b, 1);
    chk("b_restart_x_edge2", x_b, 0);
    for (int k = 0; k < 40; k++) step_b();
    chk("b_restart_model_mismatches", mism, 0);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
